// File: rtl/cb_shift_pkg.sv
// Shared mode codes, FSM state type and helpers for the universal shift register.
package cb_shift_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'd6;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Only shifts and rotates may start a burst.
    function automatic logic is_shift(input logic [MODE_W-1:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/cb_shift_next.sv
// Combinational next-value of the register for one operation; shared by manual and burst paths.
module cb_shift_next
    import cb_shift_pkg::*;
#(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [MODE_W-1:0] op,
    input  logic              sin_l,
    input  logic              sin_r,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  nxt_c
);

    always_comb begin
        nxt_c = q;
        case (op)
            MODE_LOAD: nxt_c = d;
            MODE_SHL:  nxt_c = {q[WIDTH-2:0], sin_r};
            MODE_SHR:  nxt_c = {sin_l, q[WIDTH-1:1]};
            MODE_ROL:  nxt_c = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  nxt_c = {q[0], q[WIDTH-1:1]};
            MODE_CLR:  nxt_c = RESET_VAL;
            default:   nxt_c = q;
        endcase
    end

endmodule

// File: rtl/cb_shift_reg_burst.sv
// Universal shift register with clock enable and an autonomous N-shift burst mode.
module cb_shift_reg_burst
    import cb_shift_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              start,
    output logic [WIDTH-1:0]  q,
    output logic              sout_msb,
    output logic              sout_lsb,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] dir_q, dir_d;
    logic              done_d;
    logic [WIDTH-1:0]  q_d;
    logic [MODE_W-1:0] op_c;
    logic [WIDTH-1:0]  nxt_c;

    // In a burst the latched direction drives the shifter; otherwise the live mode does.
    assign op_c = (state_q == BURST) ? dir_q : mode;

    cb_shift_next #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_next (
        .q     (q),
        .op    (op_c),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .d     (d),
        .nxt_c (nxt_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= MODE_HOLD;
            done    <= 1'b0;
            q       <= RESET_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done    <= done_d;
            q       <= q_d;
        end
    end

    // Next-state, counter, done pulse and register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        q_d     = q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start && is_shift(mode)) begin
                        if (burst_len == CNT_W'(0)) begin
                            done_d = 1'b1;
                        end else if (burst_len == CNT_W'(1)) begin
                            q_d    = nxt_c;
                            done_d = 1'b1;
                        end else begin
                            q_d     = nxt_c;
                            dir_d   = mode;
                            cnt_d   = burst_len - CNT_W'(1);
                            state_d = BURST;
                        end
                    end else begin
                        q_d = nxt_c;
                    end
                end
                BURST: begin
                    q_d   = nxt_c;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy     = (state_q == BURST);
    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

endmodule

// File: tb/tb_cb_shift_reg_burst.sv
// Bench for cb_shift_reg_burst: two instances (RESET_VAL 0x00 and 0x5A) against an arithmetic reference model.
module tb_cb_shift_reg_burst;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [3:0] burst_len;
    logic       start;

    logic [7:0] q        [2];
    logic       sout_msb [2];
    logic       sout_lsb [2];
    logic       busy     [2];
    logic       done     [2];

    int n_chk  = 0;
    int n_fail = 0;

    cb_shift_reg_burst #(.WIDTH(8), .RESET_VAL(8'h00)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
        .burst_len(burst_len), .start(start), .q(q[0]), .sout_msb(sout_msb[0]),
        .sout_lsb(sout_lsb[0]), .busy(busy[0]), .done(done[0])
    );

    cb_shift_reg_burst #(.WIDTH(8), .RESET_VAL(8'h5A)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
        .burst_len(burst_len), .start(start), .q(q[1]), .sout_msb(sout_msb[1]),
        .sout_lsb(sout_lsb[1]), .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register value as an integer, a count of shifts still owed, and a done flag.
    int   rv_m    [2] = '{32'h00, 32'h5A};
    int   q_m     [2];
    int   pend_m;
    int   dir_m;
    bit   done_m;
    bit   valid_m = 1'b0;

    function automatic int apply(input int op, input int qi, input int sl, input int sr,
                                 input int di, input int rv);
        case (op)
            1:       return di;
            2:       return (qi * 2 + sr) % 256;
            3:       return qi / 2 + sl * 128;
            4:       return (qi * 2 + qi / 128) % 256;
            5:       return qi / 2 + (qi % 2) * 128;
            6:       return rv;
            default: return qi;
        endcase
    endfunction

    function automatic bit shift_op(input int op);
        return op >= 2 && op <= 5;
    endfunction

    always begin
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 2; k++) q_m[k] = rv_m[k];
            pend_m  = 0;
            done_m  = 1'b0;
            valid_m = 1'b1;
        end else if (valid_m) begin
            done_m = 1'b0;
            if (en) begin
                if (pend_m > 0) begin
                    for (int k = 0; k < 2; k++)
                        q_m[k] = apply(dir_m, q_m[k], int'(sin_l), int'(sin_r), int'(d), rv_m[k]);
                    pend_m--;
                    if (pend_m == 0) done_m = 1'b1;
                end else if (start && shift_op(int'(mode))) begin
                    if (burst_len != 4'd0) begin
                        for (int k = 0; k < 2; k++)
                            q_m[k] = apply(int'(mode), q_m[k], int'(sin_l), int'(sin_r), int'(d), rv_m[k]);
                        dir_m  = int'(mode);
                        pend_m = int'(burst_len) - 1;
                    end
                    if (pend_m == 0) done_m = 1'b1;
                end else begin
                    for (int k = 0; k < 2; k++)
                        q_m[k] = apply(int'(mode), q_m[k], int'(sin_l), int'(sin_r), int'(d), rv_m[k]);
                end
            end
        end
        #1;
        if (valid_m) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("model q[%0d]", k), 32'(q[k]), 32'(q_m[k]));
                check($sformatf("model busy[%0d]", k), 32'(busy[k]), 32'(pend_m > 0));
                check($sformatf("model done[%0d]", k), 32'(done[k]), 32'(done_m));
                check($sformatf("model sout_msb[%0d]", k), 32'(sout_msb[k]), 32'(q_m[k] / 128));
                check($sformatf("model sout_lsb[%0d]", k), 32'(sout_lsb[k]), 32'(q_m[k] % 2));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] dv = 8'h00);
        mode = m;
        d    = dv;
        tick();
    endtask

    task automatic lit(input string name, input logic [7:0] e0, input logic [7:0] e1,
                       input logic eb, input logic ed);
        check({name, " q0"}, 32'(q[0]), 32'(e0));
        check({name, " q1"}, 32'(q[1]), 32'(e1));
        check({name, " busy"}, 32'(busy[0]), 32'(eb));
        check({name, " done"}, 32'(done[0]), 32'(ed));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00;
        sin_l = 1'b0; sin_r = 1'b0; burst_len = 4'd0; start = 1'b0;
        tick(2);
        rst = 1'b0; en = 1'b1;

        // Reset from a loaded value
        op(3'd1, 8'hA5);
        lit("load A5", 8'hA5, 8'hA5, 1'b0, 1'b0);
        rst = 1'b1; mode = 3'd0;
        tick(2);
        rst = 1'b0;
        lit("reset", 8'h00, 8'h5A, 1'b0, 1'b0);

        // Enable gating
        op(3'd1, 8'hA5);
        en = 1'b0; d = 8'h3C;
        tick(3);
        lit("en low hold", 8'hA5, 8'hA5, 1'b0, 1'b0);
        en = 1'b1;

        // Single operations
        sin_r = 1'b1; op(3'd2);
        lit("shl", 8'h4B, 8'h4B, 1'b0, 1'b0);
        sin_l = 1'b0; sin_r = 1'b0; op(3'd3);
        lit("shr", 8'h25, 8'h25, 1'b0, 1'b0);
        op(3'd1, 8'h81); op(3'd4);
        lit("rol", 8'h03, 8'h03, 1'b0, 1'b0);
        op(3'd1, 8'h81); op(3'd5);
        lit("ror", 8'hC0, 8'hC0, 1'b0, 1'b0);
        op(3'd6);
        lit("clr", 8'h00, 8'h5A, 1'b0, 1'b0);
        op(3'd1, 8'h3C); op(3'd7);
        lit("mode7", 8'h3C, 8'h3C, 1'b0, 1'b0);

        // Basic ROL burst of 3
        op(3'd1, 8'h01);
        burst_len = 4'd3; start = 1'b1; op(3'd4);
        lit("burst e1", 8'h02, 8'h02, 1'b1, 1'b0);
        start = 1'b0; op(3'd0);
        lit("burst e2", 8'h04, 8'h04, 1'b1, 1'b0);
        tick();
        lit("burst e3", 8'h08, 8'h08, 1'b0, 1'b1);
        tick();
        lit("burst after", 8'h08, 8'h08, 1'b0, 1'b0);

        // Same burst with a one-cycle stall
        op(3'd1, 8'h01);
        start = 1'b1; op(3'd4);
        start = 1'b0; mode = 3'd0; en = 1'b0;
        tick();
        lit("stall", 8'h02, 8'h02, 1'b1, 1'b0);
        en = 1'b1;
        tick();
        lit("stall e2", 8'h04, 8'h04, 1'b1, 1'b0);
        tick();
        lit("stall e3", 8'h08, 8'h08, 1'b0, 1'b1);

        // Start, mode, d and burst_len are ignored mid-burst
        op(3'd1, 8'h01);
        start = 1'b1; op(3'd4);
        burst_len = 4'd7; op(3'd1, 8'hFF);
        tick();
        lit("ignore start", 8'h08, 8'h08, 1'b0, 1'b1);
        start = 1'b0; op(3'd0);

        // burst_len = 0 and burst_len = 1
        burst_len = 4'd0; start = 1'b1; op(3'd2);
        lit("len0", 8'h08, 8'h08, 1'b0, 1'b1);
        start = 1'b0; op(3'd0);
        lit("len0 after", 8'h08, 8'h08, 1'b0, 1'b0);
        burst_len = 4'd1; start = 1'b1; sin_r = 1'b1; op(3'd2);
        lit("len1", 8'h11, 8'h11, 1'b0, 1'b1);
        start = 1'b0; sin_r = 1'b0; op(3'd0);

        // Start with a non-shift mode just loads
        burst_len = 4'd3; start = 1'b1; op(3'd1, 8'h77);
        lit("start load", 8'h77, 8'h77, 1'b0, 1'b0);
        start = 1'b0; op(3'd0);

        // burst_len beyond WIDTH wraps
        op(3'd1, 8'h01);
        burst_len = 4'd9; start = 1'b1; op(3'd5);
        start = 1'b0; mode = 3'd0;
        tick(7);
        lit("len9 pre", 8'h01, 8'h01, 1'b1, 1'b0);
        tick();
        lit("len9", 8'h80, 8'h80, 1'b0, 1'b1);

        // SHR burst with live serial input
        op(3'd1, 8'h00);
        burst_len = 4'd4; start = 1'b1; sin_l = 1'b1; op(3'd3);
        start = 1'b0; mode = 3'd0; sin_l = 1'b0; tick();
        sin_l = 1'b1; tick();
        tick();
        lit("shr live sin", 8'hD0, 8'hD0, 1'b0, 1'b1);
        sin_l = 1'b0;

        // Reset mid-burst
        op(3'd1, 8'h01);
        burst_len = 4'd5; start = 1'b1; op(3'd2);
        start = 1'b0; op(3'd0);
        lit("pre reset", 8'h04, 8'h04, 1'b1, 1'b0);
        rst = 1'b1; tick();
        lit("mid reset", 8'h00, 8'h5A, 1'b0, 1'b0);
        rst = 1'b0; tick(4);
        lit("post reset", 8'h00, 8'h5A, 1'b0, 1'b0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
